// File: rtl/alu_pkg.sv
// Shared ALU opcodes, forwarding selects and datapath widths.
// The decode/execute pipeline and the ALU both import this package.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    Add = 3'b000,
    Sub = 3'b001,
    And = 3'b010,
    Or  = 3'b011,
    Mul = 3'b100
  } e_ALUControl;

  typedef enum logic [1:0] {
    FwdRF  = 2'd0,
    FwdWB  = 2'd1,
    FwdMEM = 2'd2
  } e_FwdSel;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: the MEM producer wins over the WB producer,
// and register x0 is never forwarded.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_AW = alu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rsE,
  input  logic [DATA_W-1:0] storedVal,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regWriteM,
  input  logic [DATA_W-1:0] aluResultM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteW,
  input  logic [DATA_W-1:0] resultW,
  output logic [DATA_W-1:0] fwdVal,
  output logic [1:0]        fwdSel
);

  e_FwdSel sel;

  // The MEM result is the younger value, so it is checked first.
  always_comb begin
    fwdVal = storedVal;
    sel    = FwdRF;
    if (regWriteM && (rdM == rsE) && (rsE != '0)) begin
      fwdVal = aluResultM;
      sel    = FwdMEM;
    end else if (regWriteW && (rdW == rsE) && (rsE != '0)) begin
      fwdVal = resultW;
      sel    = FwdWB;
    end
  end

  assign fwdSel = sel;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register feeding the ALU, with MEM/WB operand
// forwarding applied combinationally on the E-stage source indices.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_AW = alu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validD,
  input  logic              stallE,
  input  logic              flushE,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rdD,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [DATA_W-1:0] immD,
  input  logic              ALUSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic              regWriteD,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regWriteM,
  input  logic [DATA_W-1:0] aluResultM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteW,
  input  logic [DATA_W-1:0] resultW,
  output logic              validE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] srcAE,
  output logic [DATA_W-1:0] srcBE,
  output logic [DATA_W-1:0] writeDataE,
  output logic [REG_AW-1:0] rdE,
  output logic              regWriteE,
  output logic [1:0]        fwdAE,
  output logic [1:0]        fwdBE
);

  logic              validQ;
  e_ALUControl       aluCtrlQ;
  logic              aluSrcQ;
  logic              regWriteQ;
  logic [REG_AW-1:0] rdQ;
  logic [REG_AW-1:0] rs1Q;
  logic [REG_AW-1:0] rs2Q;
  logic [DATA_W-1:0] rd1Q;
  logic [DATA_W-1:0] rd2Q;
  logic [DATA_W-1:0] immQ;
  logic [DATA_W-1:0] opAFwd;
  logic [DATA_W-1:0] opBFwd;

  // A stall keeps control fields but refreshes the operand registers with the
  // forwarded values, so a producer that retires from WB mid-stall is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flushE) begin
      validQ    <= 1'b0;
      aluCtrlQ  <= Add;
      aluSrcQ   <= 1'b0;
      regWriteQ <= 1'b0;
      rdQ       <= '0;
      rs1Q      <= '0;
      rs2Q      <= '0;
      rd1Q      <= '0;
      rd2Q      <= '0;
      immQ      <= '0;
    end else if (stallE) begin
      rd1Q <= opAFwd;
      rd2Q <= opBFwd;
    end else begin
      validQ    <= validD;
      aluCtrlQ  <= e_ALUControl'(ALUControlD);
      aluSrcQ   <= ALUSrcD;
      regWriteQ <= regWriteD;
      rdQ       <= rdD;
      rs1Q      <= rs1D;
      rs2Q      <= rs2D;
      rd1Q      <= rd1D;
      rd2Q      <= rd2D;
      immQ      <= immD;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwdA (
    .rsE        (rs1Q),
    .storedVal  (rd1Q),
    .rdM        (rdM),
    .regWriteM  (regWriteM),
    .aluResultM (aluResultM),
    .rdW        (rdW),
    .regWriteW  (regWriteW),
    .resultW    (resultW),
    .fwdVal     (opAFwd),
    .fwdSel     (fwdAE)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwdB (
    .rsE        (rs2Q),
    .storedVal  (rd2Q),
    .rdM        (rdM),
    .regWriteM  (regWriteM),
    .aluResultM (aluResultM),
    .rdW        (rdW),
    .regWriteW  (regWriteW),
    .resultW    (resultW),
    .fwdVal     (opBFwd),
    .fwdSel     (fwdBE)
  );

  // Store data always takes the forwarded rs2, even when srcB is the immediate.
  assign validE      = validQ;
  assign ALUControlE = aluCtrlQ;
  assign srcAE       = opAFwd;
  assign srcBE       = aluSrcQ ? immQ : opBFwd;
  assign writeDataE  = opBFwd;
  assign rdE         = rdQ;
  assign regWriteE   = regWriteQ & validQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, forwarding priority, x0, immediate
// select, stall retention, flush and asynchronous reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        validD, stallE, flushE;
  logic [4:0]  rs1D, rs2D, rdD;
  logic [31:0] rd1D, rd2D, immD;
  logic        ALUSrcD;
  logic [2:0]  ALUControlD;
  logic        regWriteD;
  logic [4:0]  rdM, rdW;
  logic        regWriteM, regWriteW;
  logic [31:0] aluResultM, resultW;
  logic        validE;
  logic [2:0]  ALUControlE;
  logic [31:0] srcAE, srcBE, writeDataE;
  logic [4:0]  rdE;
  logic        regWriteE;
  logic [1:0]  fwdAE, fwdBE;

  int checks   = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .validD      (validD),
    .stallE      (stallE),
    .flushE      (flushE),
    .rs1D        (rs1D),
    .rs2D        (rs2D),
    .rdD         (rdD),
    .rd1D        (rd1D),
    .rd2D        (rd2D),
    .immD        (immD),
    .ALUSrcD     (ALUSrcD),
    .ALUControlD (ALUControlD),
    .regWriteD   (regWriteD),
    .rdM         (rdM),
    .regWriteM   (regWriteM),
    .aluResultM  (aluResultM),
    .rdW         (rdW),
    .regWriteW   (regWriteW),
    .resultW     (resultW),
    .validE      (validE),
    .ALUControlE (ALUControlE),
    .srcAE       (srcAE),
    .srcBE       (srcBE),
    .writeDataE  (writeDataE),
    .rdE         (rdE),
    .regWriteE   (regWriteE),
    .fwdAE       (fwdAE),
    .fwdBE       (fwdBE)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [31:0] rd1,
                               input logic [4:0] rs2, input logic [31:0] rd2,
                               input logic [4:0] rd, input logic [2:0] op,
                               input logic aluSrc, input logic [31:0] imm);
    validD      = 1'b1;
    regWriteD   = 1'b1;
    rs1D        = rs1;
    rd1D        = rd1;
    rs2D        = rs2;
    rd2D        = rd2;
    rdD         = rd;
    ALUControlD = op;
    ALUSrcD     = aluSrc;
    immD        = imm;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    validD = 0; stallE = 0; flushE = 0;
    rs1D = 0; rs2D = 0; rdD = 0; rd1D = 0; rd2D = 0; immD = 0;
    ALUSrcD = 0; ALUControlD = 0; regWriteD = 0;
    rdM = 0; regWriteM = 0; aluResultM = 0;
    rdW = 0; regWriteW = 0; resultW = 0;

    #12;
    checkOutput("reset_validE", {31'd0, validE}, 32'd0);
    checkOutput("reset_regWriteE", {31'd0, regWriteE}, 32'd0);
    checkOutput("reset_ALUControlE", {29'd0, ALUControlE}, 32'd0);
    checkOutput("reset_srcAE", srcAE, 32'd0);
    checkOutput("reset_srcBE", srcBE, 32'd0);
    checkOutput("reset_writeDataE", writeDataE, 32'd0);
    checkOutput("reset_rdE", {27'd0, rdE}, 32'd0);
    checkOutput("reset_fwd", {28'd0, fwdAE, fwdBE}, 32'd0);
    reset = 1'b0;

    // Plain load, no producers matching
    applyStimulus(5'd1, 32'd5, 5'd2, 32'd7, 5'd4, 3'b000, 1'b0, 32'd0);
    stepEdge();
    checkOutput("load_srcAE", srcAE, 32'd5);
    checkOutput("load_srcBE", srcBE, 32'd7);
    checkOutput("load_fwd", {28'd0, fwdAE, fwdBE}, 32'd0);
    checkOutput("load_validE", {31'd0, validE}, 32'd1);
    checkOutput("load_regWriteE", {31'd0, regWriteE}, 32'd1);
    checkOutput("load_rdE", {27'd0, rdE}, 32'd4);

    // Both MEM and WB match rs1: MEM wins, then WB once MEM drops
    applyStimulus(5'd3, 32'h33, 5'd2, 32'd7, 5'd6, 3'b001, 1'b0, 32'd0);
    regWriteM = 1; rdM = 5'd3; aluResultM = 32'h10;
    regWriteW = 1; rdW = 5'd3; resultW = 32'h20;
    stepEdge();
    checkOutput("dual_srcAE", srcAE, 32'h10);
    checkOutput("dual_fwdAE", {30'd0, fwdAE}, 32'd2);
    checkOutput("dual_srcBE", srcBE, 32'd7);
    checkOutput("dual_ALUControlE", {29'd0, ALUControlE}, 32'd1);
    regWriteM = 0;
    #1;
    checkOutput("wb_srcAE", srcAE, 32'h20);
    checkOutput("wb_fwdAE", {30'd0, fwdAE}, 32'd1);

    // x0 is never forwarded
    regWriteW = 0;
    applyStimulus(5'd0, 32'd0, 5'd2, 32'd7, 5'd6, 3'b000, 1'b0, 32'd0);
    stepEdge();
    regWriteM = 1; rdM = 5'd0; aluResultM = 32'hFF;
    #1;
    checkOutput("x0_srcAE", srcAE, 32'd0);
    checkOutput("x0_fwdAE", {30'd0, fwdAE}, 32'd0);

    // Immediate on srcB, store data still forwarded from WB
    regWriteM = 0;
    regWriteW = 1; rdW = 5'd2; resultW = 32'd9;
    applyStimulus(5'd1, 32'd5, 5'd2, 32'd7, 5'd8, 3'b010, 1'b1, 32'hFFFFFFFC);
    stepEdge();
    checkOutput("imm_srcBE", srcBE, 32'hFFFFFFFC);
    checkOutput("imm_writeDataE", writeDataE, 32'd9);
    checkOutput("imm_fwdBE", {30'd0, fwdBE}, 32'd1);
    checkOutput("imm_srcAE", srcAE, 32'd5);

    // Stall retention across WB retirement
    regWriteW = 1; rdW = 5'd5; resultW = 32'h55;
    applyStimulus(5'd5, 32'h11, 5'd6, 32'h22, 5'd9, 3'b011, 1'b0, 32'd0);
    stepEdge();
    checkOutput("stall0_srcAE", srcAE, 32'h55);
    checkOutput("stall0_fwdAE", {30'd0, fwdAE}, 32'd1);
    stallE = 1;
    applyStimulus(5'd7, 32'h77, 5'd8, 32'h88, 5'd10, 3'b100, 1'b1, 32'h1234);
    stepEdge();
    regWriteW = 0;
    #1;
    checkOutput("stall1_srcAE", srcAE, 32'h55);
    checkOutput("stall1_fwdAE", {30'd0, fwdAE}, 32'd0);
    stepEdge();
    checkOutput("stall2_srcAE", srcAE, 32'h55);
    stepEdge();
    checkOutput("stall3_srcAE", srcAE, 32'h55);
    checkOutput("stall3_srcBE", srcBE, 32'h22);
    checkOutput("stall3_ALUControlE", {29'd0, ALUControlE}, 32'd3);
    checkOutput("stall3_rdE", {27'd0, rdE}, 32'd9);
    checkOutput("stall3_validE", {31'd0, validE}, 32'd1);

    // Flush beats stall
    flushE = 1;
    stepEdge();
    checkOutput("flush_validE", {31'd0, validE}, 32'd0);
    checkOutput("flush_regWriteE", {31'd0, regWriteE}, 32'd0);
    checkOutput("flush_ALUControlE", {29'd0, ALUControlE}, 32'd0);
    checkOutput("flush_rdE", {27'd0, rdE}, 32'd0);
    checkOutput("flush_srcAE", srcAE, 32'd0);
    flushE = 0;
    stallE = 0;

    // Asynchronous reset between edges
    applyStimulus(5'd1, 32'd5, 5'd2, 32'd7, 5'd4, 3'b001, 1'b0, 32'd0);
    stepEdge();
    checkOutput("pre_reset_srcAE", srcAE, 32'd5);
    checkOutput("pre_reset_validE", {31'd0, validE}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_validE", {31'd0, validE}, 32'd0);
    checkOutput("areset_regWriteE", {31'd0, regWriteE}, 32'd0);
    checkOutput("areset_ALUControlE", {29'd0, ALUControlE}, 32'd0);
    checkOutput("areset_srcAE", srcAE, 32'd0);
    checkOutput("areset_srcBE", srcBE, 32'd0);
    checkOutput("areset_rdE", {27'd0, rdE}, 32'd0);
    #1;
    reset = 1'b0;
    stepEdge();
    checkOutput("post_reset_validE", {31'd0, validE}, 32'd1);
    checkOutput("post_reset_srcBE", srcBE, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register with operand forwarding.
- Captures decoded instruction fields each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives srcAE, srcBE and ALUControlE directly into the execute-stage ALU; also supplies store data and destination info to the EX/MEM stage.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- validD  in  1  decode slot holds a real instruction
- stallE  in  1  hold E-stage contents
- flushE  in  1  replace E-stage contents with a bubble
- rs1D, rs2D  in  REG_AW  source register indices
- rdD  in  REG_AW  destination index
- rd1D, rd2D  in  DATA_W  register-file read data
- immD  in  DATA_W  sign-extended immediate
- ALUSrcD  in  1  1 = srcB from immediate
- ALUControlD  in  3  e_ALUControl opcode
- regWriteD  in  1  instruction writes rd
- rdM, regWriteM, aluResultM  in  REG_AW/1/DATA_W  MEM-stage producer
- rdW, regWriteW, resultW  in  REG_AW/1/DATA_W  WB-stage producer
- validE  out  1  E slot valid
- ALUControlE  out  3  to ALU
- srcAE, srcBE  out  DATA_W  to ALU
- writeDataE  out  DATA_W  forwarded rs2 value, for stores
- rdE  out  REG_AW  destination
- regWriteE  out  1  gated by validE
- fwdAE, fwdBE  out  2  forward select, e_FwdSel: 0 = RF, 1 = WB, 2 = MEM

Behaviour:
- Reset (async, immediate):
  - All E registers clear.
  - validE = 0, regWriteE = 0, ALUControlE = Add (3'b000).
  - rdE = 0, srcAE = srcBE = writeDataE = 0, fwdAE = fwdBE = 0.
  - Reset mid-stall or mid-flush has the same effect. The first capture happens on the first rising edge after reset deasserts.
- Per rising edge, with priority flush > stall > load:
  - flushE = 1: bubble. validE = 0, regWriteE = 0, ALUControlE = Add, rdE = 0, operands = 0. This applies even if stallE = 1 in the same cycle.
  - stallE = 1 (no flush): control fields hold.
    - The rs1/rs2 operand registers reload with the current forwarded values (opA_fwd, opB_fwd).
    - This preserves a producer's value after it retires from WB during a multi-cycle stall.
    - Recapture is idempotent: the register-file value is re-chosen only if no match exists.
  - Otherwise: load all D-side fields into E.
    - validE = validD.
    - Stored regWrite = regWriteD.
- Output gating: regWriteE output = stored regWrite AND validE.
- Forwarding (combinational, E-stage indices rs1E/rs2E), for each source:
  - MEM match: regWriteM and rdM == rsE and rsE != 0 → aluResultM, fwd = 2.
  - Else WB match: regWriteW and rdW == rsE and rsE != 0 → resultW, fwd = 1.
  - Else stored RF value, fwd = 0.
  - MEM wins over WB when both match.
  - Index 0 is never forwarded and reads as stored rd1/rd2.
- Operand outputs:
  - srcAE = opA_fwd.
  - srcBE = ALUSrcE ? immE : opB_fwd.
  - writeDataE = opB_fwd, regardless of ALUSrcE.
- Latency: one cycle from D inputs to E outputs. Forwarding paths add zero cycles (combinational from M/W inputs).
- Bubbles (validE = 0) still drive defined operands but never assert regWriteE.
- Load-use detection is out of scope; stallE/flushE come from the hazard unit.

Decomposition:
- Shared package alu_pkg:
  - e_ALUControl enum (Add/Sub/And/Or/Mul), moved out of the ALU file.
  - e_FwdSel enum.
  - DATA_W and REG_AW constants.
- One sub-module fwd_mux, instantiated twice (A and B):
  - Inputs: rsE, stored value, M/W producer ports.
  - Outputs: forwarded value and fwd select.

Test Plan:
- Plain load: rs1D = 1, rd1D = 5, rs2D = 2, rd2D = 7, ALUControlD = Add, validD = 1, no M/W matches → next cycle srcAE = 5, srcBE = 7, fwdAE = fwdBE = 0, validE = 1.
- Dual match: rs1E = 3 with regWriteM = 1, rdM = 3, aluResultM = 0x10 and regWriteW = 1, rdW = 3, resultW = 0x20 → srcAE = 0x10, fwdAE = 2. Drop regWriteM → srcAE = 0x20, fwdAE = 1.
- x0 never forwarded: rs1E = 0, rdM = 0, regWriteM = 1, aluResultM = 0xFF, rd1 stored = 0 → srcAE = 0, fwdAE = 0.
- Immediate select: ALUSrcD = 1, immD = 0xFFFFFFFC, rs2 forwarded from WB as 9 → srcBE = 0xFFFFFFFC, writeDataE = 9.
- Stall retention: stallE held 3 cycles.
  - Cycle 1: WB forwards resultW = 0x55 to rs1E.
  - Cycles 2–3: regWriteW = 0.
  - Required: srcAE stays 0x55 throughout; ALUControlE/rdE unchanged.
- Flush and reset:
  - flushE = stallE = 1 → validE = 0, regWriteE = 0, ALUControlE = Add.
  - Assert reset between edges → all outputs 0 immediately, without waiting for a clock edge.
